// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

    localparam int unsigned FLUSH_CNT_W    = 3;
    localparam int unsigned REDIRECT_CNT_W = 16;

    // The timer counts down to zero, so a depth of D is loaded as D-1.
    function automatic logic [FLUSH_CNT_W-1:0] flush_load_val(
        input logic [FLUSH_CNT_W-1:0] depth
    );
        return depth - 1'b1;
    endfunction

endpackage

// File: rtl/pc_ctrl_flush_timer.sv
// Squash-window timer: holds busy for `depth` cycles after a load pulse.
module flush_timer
    import pc_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [FLUSH_CNT_W-1:0] depth,
    output logic                   busy,
    output logic                   done
);

    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load) begin
            cnt_d  = flush_load_val(depth);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    // Last cycle of the window: the owner returns to fetching on the next edge.
    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/pc_ctrl.sv
// PC and fetch sequencer with taken-branch redirect and fixed-length squash window.
// Optional redirect counter output when PC_CTRL_PERF_EN is defined.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter int unsigned       FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              halt,
    input  logic              jmp_true,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic              flush,
    output logic              halted
`ifdef PC_CTRL_PERF_EN
    ,
    output logic [REDIRECT_CNT_W-1:0] redirect_cnt
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FlushDepth = FLUSH_DEPTH[FLUSH_CNT_W-1:0];
    localparam logic [ADDR_W-1:0]      PcOne      = ADDR_W'(1);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              halted_q, halted_d;

    logic              flush_load;
    logic              flush_busy;
    logic              flush_done;
    logic              fetch_acc;
    logic              redirect;

    flush_timer u_flush_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (flush_load),
        .depth (FlushDepth),
        .busy  (flush_busy),
        .done  (flush_done)
    );

    assign imem_req  = (state_q == FETCH) && !stall;
    assign imem_addr = pc_q;
    assign fetch_acc = imem_req && imem_ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = 1'b0;
        if_pc_d    = if_pc_q;
        flush_load = 1'b0;
        redirect   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // Redirect beats halt and fetch; a same-cycle ack is dropped.
                if (jmp_true) begin
                    pc_d       = jmp_target;
                    state_d    = FLUSH;
                    flush_load = 1'b1;
                    redirect   = 1'b1;
                end else if (halt) begin
                    state_d = HALT;
                end else if (fetch_acc) begin
                    pc_d       = pc_q + PcOne;
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                end
            end
            FLUSH: begin
                if (flush_busy && flush_done) begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_PC;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            halted_q   <= halted_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign flush    = flush_busy;
    assign halted   = halted_q;

`ifdef PC_CTRL_PERF_EN
    logic [REDIRECT_CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redirect && (redirect_cnt_q != {REDIRECT_CNT_W{1'b1}})) begin
            redirect_cnt_d = redirect_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule
